// File: rtl/data_memory_sized_if.sv
// Request/response bundle for the byte-addressed data memory.
// The master issues loads and stores; the slave (memory) answers one cycle later.
interface data_memory_sized_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] adr;
    logic [63:0]       datain;
    logic              rsp_valid;
    logic [63:0]       dataout;
    logic              fault;
    logic              busy;

    modport master (
        output req_valid, we, size, sign_ext, adr, datain,
        input  req_ready, rsp_valid, dataout, fault, busy
    );

    modport slave (
        input  req_valid, we, size, sign_ext, adr, datain,
        output req_ready, rsp_valid, dataout, fault, busy
    );
endinterface

// File: rtl/data_memory_sized.sv
// Byte-addressed data memory with sized little-endian loads/stores, bounds and
// alignment faults, and a one-byte-per-cycle zeroing sequence after reset.
module data_memory_sized #(
    parameter int DEPTH_BYTES = 32,
    parameter int ADDR_W      = 64
) (
    input logic                clk,
    input logic                rst,
    data_memory_sized_if.slave bus
);
    localparam int IW = $clog2(DEPTH_BYTES);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state, state_next;
    logic [IW-1:0]     clr_idx;
    logic [7:0]        mem [DEPTH_BYTES];

    logic              accept;
    logic              flt;
    logic              wr_en;
    logic [3:0]        nbytes;
    logic [2:0]        align_mask;
    logic [ADDR_W:0]   end_addr;
    logic [IW-1:0]     base;
    logic [63:0]       raw;
    logic [63:0]       load_val;

    function automatic logic [63:0] extend(input logic [63:0] r, input logic [1:0] sz,
                                           input logic sx);
        case (sz)
            2'b00:   extend = {{56{sx & r[7]}},  r[7:0]};
            2'b01:   extend = {{48{sx & r[15]}}, r[15:0]};
            2'b10:   extend = {{32{sx & r[31]}}, r[31:0]};
            default: extend = r;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_idx == IW'(DEPTH_BYTES - 1))
            state_next = READY;
    end

    always_comb begin
        bus.req_ready = (state == READY);
        bus.busy      = (state == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst)                 clr_idx <= '0;
        else if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
    end

    // Access decode: the end address is computed one bit wider than the
    // address so an access near the top of the address space cannot wrap.
    always_comb begin
        case (bus.size)
            2'b00:   begin nbytes = 4'd1; align_mask = 3'b000; end
            2'b01:   begin nbytes = 4'd2; align_mask = 3'b001; end
            2'b10:   begin nbytes = 4'd4; align_mask = 3'b011; end
            default: begin nbytes = 4'd8; align_mask = 3'b111; end
        endcase
        end_addr = {1'b0, bus.adr} + (ADDR_W+1)'(nbytes);
        flt      = ((bus.adr[2:0] & align_mask) != 3'b000) ||
                   (end_addr > (ADDR_W+1)'(DEPTH_BYTES));
        accept   = bus.req_valid && bus.req_ready;
        wr_en    = accept && bus.we && !flt && !rst;
        base     = bus.adr[IW-1:0];
    end

    always_comb begin
        raw = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < int'(nbytes))
                raw[8*k +: 8] = mem[base + IW'(k)];
        end
        load_val = extend(raw, bus.size, bus.sign_ext);
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_idx] <= 8'h00;
        end else if (wr_en) begin
            for (int k = 0; k < 8; k++) begin
                if (k < int'(nbytes))
                    mem[base + IW'(k)] <= bus.datain[8*k +: 8];
            end
        end
    end

    // Response stage: registered at the accept edge, held between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.fault     <= 1'b0;
            bus.dataout   <= '0;
        end else if (accept) begin
            bus.rsp_valid <= 1'b1;
            bus.fault     <= flt;
            bus.dataout   <= (bus.we || flt) ? 64'd0 : load_val;
        end else begin
            bus.rsp_valid <= 1'b0;
        end
    end
endmodule
